spectral_flux_multiband: RTL and testbench

- Parametrised successor to the single-frame spectral flux stage.
- Consumes per-bin magnitude-squared beats from the magnitude module and computes half-wave-rectified spectral flux per frame: a total, plus NUM_BANDS equal-width band sums.
- Keeps a HIST_DEPTH-frame moving average and flags onsets against a programmable multiple of it, with warm-up and refractory suppression.
- Feeds the autocorrelation / tempo stage. No backpressure.

---
 rtl/spectral_flux_multiband.sv | 206 ++++++++++++++++++++
 tb/tb_spectral_flux_multiband.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_flux_multiband.sv
// Multiband half-wave-rectified spectral flux with moving-average onset detection.
// Optional per-band onset detection is enabled by defining SPECTRAL_FLUX_BAND_BEAT_EN.
module spectral_flux_multiband #(
  parameter int unsigned N_BINS     = 1024,
  parameter int unsigned W          = 32,
  parameter int unsigned NUM_BANDS  = 4,
  parameter int unsigned HIST_DEPTH = 32,
  parameter int unsigned THRESH_Q2  = 8,
  parameter int unsigned REFRACTORY = 4
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             mag_valid,
  input  logic [W-1:0]                                     mag_sq,
  input  logic [$clog2(N_BINS)-1:0]                        bin_index,
  input  logic                                             frame_last,
  output logic                                             flux_valid,
  output logic [W+$clog2(N_BINS)-1:0]                      flux_total,
  output logic [NUM_BANDS*(W+$clog2(N_BINS))-1:0]          flux_band,
  output logic                                             beat_valid,
  output logic [NUM_BANDS-1:0]                             beat_band,
  output logic                                             warm,
  output logic                                             frame_overrun
);

  localparam int unsigned LOG2N = $clog2(N_BINS);
  localparam int unsigned LOG2B = $clog2(NUM_BANDS);
  localparam int unsigned LOG2H = $clog2(HIST_DEPTH);
  localparam int unsigned FW    = W + LOG2N;
  localparam int unsigned HSW   = FW + LOG2H;
  localparam int unsigned RW    = $clog2(REFRACTORY + 1);

  typedef enum logic [1:0] {S_ACCUM, S_CLOSE, S_EVAL, S_OUT} state_t;

  // thr = (mean * THRESH_Q2) >> 2, mean = sum >> log2(HIST_DEPTH)
  function automatic logic [FW:0] thr_of(input logic [HSW-1:0] sum);
    logic [FW+2:0] p;
    p = (FW+3)'(FW'(sum >> LOG2H)) * (FW+3)'(THRESH_Q2);
    return (FW+1)'(p >> 2);
  endfunction

  logic [W-1:0]     r_prev_mem [N_BINS];
  logic [W-1:0]     r_s1_prev;
  logic             r_s1_vld, r_s1_last;
  logic [W-1:0]     r_s1_mag;
  logic [LOG2B-1:0] r_s1_band;
  logic             r_s2_vld, r_s2_last;
  logic [W-1:0]     r_s2_d;
  logic [LOG2B-1:0] r_s2_band;
  logic [FW-1:0]    r_acc_total;
  logic [FW-1:0]    r_acc_band [NUM_BANDS];
  logic [FW-1:0]    r_sh_total;
  logic [FW-1:0]    r_sh_band [NUM_BANDS];
  logic             r_sh_first;
  logic             r_first;
  state_t           r_state;
  logic [FW:0]      r_thr;
  logic [FW-1:0]    r_hist [HIST_DEPTH];
  logic [HSW-1:0]   r_hist_sum;
  logic [LOG2H-1:0] r_hist_idx;
  logic [RW-1:0]    r_refr;

  logic [W-1:0]     w_d;
  logic [W-1:0]     w_add [NUM_BANDS];
  logic             w_beat;

  // Previous-frame magnitudes: read-before-write, deliberately not reset
  always_ff @(posedge clk) begin
    if (mag_valid) r_prev_mem[bin_index] <= mag_sq;
    r_s1_prev <= r_prev_mem[bin_index];
  end

  always_comb begin
    w_d = r_first ? '0 : r_s2_d;
    for (int b = 0; b < NUM_BANDS; b++) begin
      w_add[b] = (r_s2_band == LOG2B'(b)) ? w_d : '0;
    end
    w_beat = warm & (r_refr == '0) & ({1'b0, r_sh_total} > r_thr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld      <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_mag      <= '0;
      r_s1_band     <= '0;
      r_s2_vld      <= 1'b0;
      r_s2_last     <= 1'b0;
      r_s2_d        <= '0;
      r_s2_band     <= '0;
      r_acc_total   <= '0;
      r_sh_total    <= '0;
      r_sh_first    <= 1'b0;
      r_first       <= 1'b1;
      r_state       <= S_ACCUM;
      r_thr         <= '0;
      r_hist_sum    <= '0;
      r_hist_idx    <= '0;
      r_refr        <= '0;
      flux_valid    <= 1'b0;
      flux_total    <= '0;
      flux_band     <= '0;
      beat_valid    <= 1'b0;
      warm          <= 1'b0;
      frame_overrun <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_acc_band[b] <= '0;
        r_sh_band[b]  <= '0;
      end
      for (int h = 0; h < HIST_DEPTH; h++) r_hist[h] <= '0;
    end else begin
      r_s1_vld   <= mag_valid;
      r_s1_last  <= mag_valid & frame_last;
      r_s1_mag   <= mag_sq;
      r_s1_band  <= bin_index[LOG2N-1 -: LOG2B];
      r_s2_vld   <= r_s1_vld;
      r_s2_last  <= r_s1_last;
      r_s2_d     <= (r_s1_mag > r_s1_prev) ? r_s1_mag - r_s1_prev : '0;
      r_s2_band  <= r_s1_band;
      flux_valid <= 1'b0;
      beat_valid <= 1'b0;

      // S3: accumulate, or close the frame into the shadow registers
      if (r_s2_vld) begin
        if (r_s2_last) begin
          r_acc_total <= '0;
          for (int b = 0; b < NUM_BANDS; b++) r_acc_band[b] <= '0;
          if (r_state == S_ACCUM) begin
            r_sh_total <= r_acc_total + FW'(w_d);
            for (int b = 0; b < NUM_BANDS; b++) r_sh_band[b] <= r_acc_band[b] + FW'(w_add[b]);
            r_sh_first <= r_first;
            r_first    <= 1'b0;
          end else begin
            frame_overrun <= 1'b1;
          end
        end else begin
          r_acc_total <= r_acc_total + FW'(w_d);
          for (int b = 0; b < NUM_BANDS; b++) r_acc_band[b] <= r_acc_band[b] + FW'(w_add[b]);
        end
      end

      case (r_state)
        S_ACCUM: if (r_s2_vld && r_s2_last) r_state <= S_CLOSE;
        S_CLOSE: begin
          r_thr   <= thr_of(r_hist_sum);
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          flux_valid <= 1'b1;
          flux_total <= r_sh_total;
          for (int b = 0; b < NUM_BANDS; b++) flux_band[b*FW +: FW] <= r_sh_band[b];
          beat_valid <= w_beat;
          if (!r_sh_first) begin
            r_hist[r_hist_idx] <= r_sh_total;
            r_hist_sum <= r_hist_sum + HSW'(r_sh_total) - HSW'(r_hist[r_hist_idx]);
            r_hist_idx <= r_hist_idx + LOG2H'(1);
            if (r_hist_idx == LOG2H'(HIST_DEPTH - 1)) warm <= 1'b1;
          end
          if (w_beat) r_refr <= RW'(REFRACTORY);
          else if (r_refr != '0) r_refr <= r_refr - RW'(1);
          r_state <= S_OUT;
        end
        S_OUT:   r_state <= S_ACCUM;
        default: r_state <= S_ACCUM;
      endcase
    end
  end

`ifdef SPECTRAL_FLUX_BAND_BEAT_EN
  logic [FW-1:0]        r_bhist [NUM_BANDS][HIST_DEPTH];
  logic [HSW-1:0]       r_bsum  [NUM_BANDS];
  logic [FW:0]          r_bthr  [NUM_BANDS];
  logic [NUM_BANDS-1:0] r_beat_band;

  // Per-band history and thresholds; the index and refractory are shared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_band <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_bsum[b] <= '0;
        r_bthr[b] <= '0;
        for (int h = 0; h < HIST_DEPTH; h++) r_bhist[b][h] <= '0;
      end
    end else begin
      r_beat_band <= '0;
      if (r_state == S_CLOSE) begin
        for (int b = 0; b < NUM_BANDS; b++) r_bthr[b] <= thr_of(r_bsum[b]);
      end
      if (r_state == S_EVAL) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          r_beat_band[b] <= warm & (r_refr == '0) & ({1'b0, r_sh_band[b]} > r_bthr[b]);
          if (!r_sh_first) begin
            r_bhist[b][r_hist_idx] <= r_sh_band[b];
            r_bsum[b] <= r_bsum[b] + HSW'(r_sh_band[b]) - HSW'(r_bhist[b][r_hist_idx]);
          end
        end
      end
    end
  end

  assign beat_band = r_beat_band;
`else
  assign beat_band = '0;
`endif

endmodule

// File: tb/tb_spectral_flux_multiband.sv
// Scoreboard bench for spectral_flux_multiband: a frame-level model queues expectations,
// a monitor pops them on flux_valid; directed checks confirm hand-computed values.
module tb_spectral_flux_multiband;
  localparam int NB     = 1024;
  localparam int W      = 32;
  localparam int NBANDS = 4;
  localparam int HD     = 32;
  localparam int FW     = W + 10;

  logic                 clk;
  logic                 reset_n;
  logic                 mag_valid;
  logic [W-1:0]         mag_sq;
  logic [9:0]           bin_index;
  logic                 frame_last;
  logic                 flux_valid;
  logic [FW-1:0]        flux_total;
  logic [NBANDS*FW-1:0] flux_band;
  logic                 beat_valid;
  logic [NBANDS-1:0]    beat_band;
  logic                 warm;
  logic                 frame_overrun;

  spectral_flux_multiband #(
    .N_BINS(NB), .W(W), .NUM_BANDS(NBANDS), .HIST_DEPTH(HD), .THRESH_Q2(8), .REFRACTORY(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mag_valid(mag_valid), .mag_sq(mag_sq),
    .bin_index(bin_index), .frame_last(frame_last), .flux_valid(flux_valid),
    .flux_total(flux_total), .flux_band(flux_band), .beat_valid(beat_valid),
    .beat_band(beat_band), .warm(warm), .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]          total;
    logic [NBANDS*64-1:0] band;
    bit                   beat;
    bit                   warm;
    int                   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  logic [63:0] obs_total = '0;
  logic [63:0] obs_band3 = '0;
  bit          obs_beat  = 1'b0;
  bit          obs_warm  = 1'b0;
  int          n_out     = 0;

  // Frame-level reference model state
  logic [W-1:0] m_prev [NB];
  bit           m_first;
  logic [63:0]  m_acc;
  logic [63:0]  m_accb [NBANDS];
  logic [63:0]  m_hist [HD];
  logic [63:0]  m_sum;
  int           m_idx;
  bit           m_warm;
  int           m_refr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && flux_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_flux_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("flux_total", 64'(flux_total), e.total);
        for (int b = 0; b < NBANDS; b++)
          chk($sformatf("flux_band%0d", b), 64'(flux_band[b*FW +: FW]), e.band[b*64 +: 64]);
        chk("beat_valid", 64'(beat_valid), 64'(e.beat));
        chk("warm", 64'(warm), 64'(e.warm));
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
`ifndef SPECTRAL_FLUX_BAND_BEAT_EN
        chk("beat_band", 64'(beat_band), 64'd0);
`endif
      end
      obs_total = 64'(flux_total);
      obs_band3 = 64'(flux_band[3*FW +: FW]);
      obs_beat  = beat_valid;
      obs_warm  = warm;
      n_out++;
    end
  end

  task automatic model_reset();
    m_first = 1'b1;
    m_acc   = '0;
    m_sum   = '0;
    m_idx   = 0;
    m_warm  = 1'b0;
    m_refr  = 0;
    for (int b = 0; b < NBANDS; b++) m_accb[b] = '0;
    for (int h = 0; h < HD; h++) m_hist[h] = '0;
  endtask

  task automatic model_close(input bit ovr, input int c);
    exp_t        e;
    logic [63:0] thr;
    if (!ovr) begin
      e.total = m_acc;
      for (int b = 0; b < NBANDS; b++) e.band[b*64 +: 64] = m_accb[b];
      thr    = ((m_sum >> 5) * 64'd8) >> 2;
      e.beat = m_warm && (m_refr == 0) && (m_acc > thr);
      if (!m_first) begin
        m_sum = m_sum + m_acc - m_hist[m_idx];
        m_hist[m_idx] = m_acc;
        if (m_idx == HD - 1) m_warm = 1'b1;
        m_idx = (m_idx + 1) % HD;
      end
      if (e.beat) m_refr = 4;
      else if (m_refr != 0) m_refr = m_refr - 1;
      e.warm = m_warm;
      e.cyc  = c + 5;
      exp_q.push_back(e);
      m_first = 1'b0;
    end
    m_acc = '0;
    for (int b = 0; b < NBANDS; b++) m_accb[b] = '0;
  endtask

  task automatic send_beat(input int bin, input logic [W-1:0] mag, input bit last, input bit ovr);
    logic [W-1:0] d;
    mag_valid  = 1'b1;
    bin_index  = 10'(bin);
    mag_sq     = mag;
    frame_last = last;
    d = (mag > m_prev[bin]) ? mag - m_prev[bin] : '0;
    m_prev[bin] = mag;
    if (!m_first) begin
      m_acc = m_acc + 64'(d);
      m_accb[bin / (NB / NBANDS)] = m_accb[bin / (NB / NBANDS)] + 64'(d);
    end
    if (last) model_close(ovr, cyc);
    @(posedge clk);
    #1;
    mag_valid  = 1'b0;
    frame_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nbins beats spread evenly over the bin range; bin 0 carries v0, the rest v
  task automatic send_frame(input int nbins, input logic [W-1:0] v0, input logic [W-1:0] v,
                            input int gap, input bit ovr);
    for (int i = 0; i < nbins; i++)
      send_beat(i * (NB / nbins), (i == 0) ? v0 : v, i == nbins - 1, ovr);
    if (gap > 0) idle(gap);
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset_n    = 1'b0;
    mag_valid  = 1'b0;
    frame_last = 1'b0;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    #1;
    chk({tag, "_flux_valid"}, 64'(flux_valid), 64'd0);
    chk({tag, "_flux_total"}, 64'(flux_total), 64'd0);
    chk({tag, "_flux_band_nonzero"}, 64'(flux_band != '0), 64'd0);
    chk({tag, "_beat_valid"}, 64'(beat_valid), 64'd0);
    chk({tag, "_beat_band"}, 64'(beat_band), 64'd0);
    chk({tag, "_warm"}, 64'(warm), 64'd0);
    chk({tag, "_frame_overrun"}, 64'(frame_overrun), 64'd0);
  endtask

  // 33 short frames after reset: first is discarded, then 32 frames of flux 1000 on bin 0
  task automatic warmup();
    for (int f = 0; f <= 32; f++) send_frame(4, W'(1000 * f), 10, 8, 1'b0);
    chk("warmup_warm", 64'(obs_warm), 64'd1);
    chk("warmup_total", obs_total, 64'd1000);
  endtask

  initial begin
    reset_n    = 1'b0;
    mag_valid  = 1'b0;
    mag_sq     = '0;
    bin_index  = '0;
    frame_last = 1'b0;
    for (int i = 0; i < NB; i++) m_prev[i] = '0;
    model_reset();

    do_reset("por");

    for (int i = 0; i < 300; i++) send_beat(i, 7, 1'b0, 1'b0);
    do_reset("midframe");
    send_frame(NB, 500, 500, 8, 1'b0);
    chk("first_frame_outputs", 64'(n_out), 64'd1);
    chk("first_frame_total", obs_total, 64'd0);

    send_frame(NB, 100, 100, 8, 1'b0);
    send_frame(NB, 150, 150, 8, 1'b0);
    chk("rise_total", obs_total, 64'd51200);
    chk("rise_band3", obs_band3, 64'd12800);
    chk("rise_beat", 64'(obs_beat), 64'd0);
    chk("rise_warm", 64'(obs_warm), 64'd0);
    send_frame(NB, 100, 100, 8, 1'b0);
    chk("fall_total", obs_total, 64'd0);

    do_reset("warm_a");
    warmup();
    send_frame(4, 32000 + 2001, 10, 8, 1'b0);
    chk("step2001_total", obs_total, 64'd2001);
    chk("step2001_beat", 64'(obs_beat), 64'd1);
    for (int r = 1; r <= 4; r++) begin
      send_frame(4, W'(34001 + 5000 * r), 10, 8, 1'b0);
      chk($sformatf("refractory%0d_beat", r), 64'(obs_beat), 64'd0);
    end
    send_frame(4, 34001 + 25000, 10, 8, 1'b0);
    chk("post_refractory_beat", 64'(obs_beat), 64'd1);

    do_reset("warm_b");
    warmup();
    send_frame(4, 32000 + 2000, 10, 8, 1'b0);
    chk("step2000_total", obs_total, 64'd2000);
    chk("step2000_beat", 64'(obs_beat), 64'd0);

    send_frame(4, 35000, 10, 0, 1'b0);
    send_frame(2, 35000, 10, 8, 1'b1);
    chk("overrun_flag", 64'(frame_overrun), 64'd1);
    send_frame(4, 36500, 10, 8, 1'b0);
    chk("after_overrun_total", obs_total, 64'd1500);
    chk("overrun_sticky", 64'(frame_overrun), 64'd1);

    idle(10);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_chk++;
      n_err++;
      $display("FAIL missing_flux_valid: got 0 expected 1");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
